// File: rtl/subst_layer_iter.sv
// Iterative ASCON substitution layer: COLS_PER_CYCLE 5-bit s-boxes sweep the
// 64 columns of the 320-bit state in place, one column group per clock.
module subst_layer_iter #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int NGROUPS = 64 / COLS_PER_CYCLE;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NGROUPS - 1);

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t             r_fsm;
  logic [CNT_W-1:0] r_cnt;
  logic [319:0]     r_state;
  logic             r_busy;
  logic             r_done;
  logic [319:0]     w_subst;

  // Column j is {x0[j],x1[j],x2[j],x3[j],x4[j]} with x0 the MSB; x0 occupies state[319:256].
  function automatic logic [319:0] substGroup(input logic [319:0] s,
                                              input logic [CNT_W-1:0] grp);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [4:0]  sIn, sOut;
    logic [5:0]  col;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      col     = 6'(int'(grp) * COLS_PER_CYCLE + k);
      sIn     = {x0[col], x1[col], x2[col], x3[col], x4[col]};
      sOut    = SBOX[sIn];
      x0[col] = sOut[4];
      x1[col] = sOut[3];
      x2[col] = sOut[2];
      x3[col] = sOut[1];
      x4[col] = sOut[0];
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  always_comb begin
    w_subst = substGroup(r_state, r_cnt);
  end

  // DONE accepts a new start directly so back-to-back runs lose no cycle.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_state <= state_i;
            r_cnt   <= '0;
            r_fsm   <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_state <= w_subst;
          if (r_cnt == LAST_GROUP) begin
            r_fsm  <= DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_state <= state_i;
            r_cnt   <= '0;
            r_fsm   <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_fsm <= IDLE;
          end
        end
        default: begin
          r_fsm  <= IDLE;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = r_state;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_subst_layer_iter.sv
// Directed bench for subst_layer_iter: four instances (C=4,1,8,64) share the
// stimulus; results, busy length and done timing are checked per instance.
module tb_subst_layer_iter;

  localparam logic [319:0] ZERO_IN    = '0;
  localparam logic [319:0] ONES_IN    = '1;
  localparam logic [319:0] ZERO_RES   = {64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
  localparam logic [319:0] ONES_RES   = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF,
                                         64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  localparam logic [319:0] SINGLE_IN  = {64'h0, 64'h0, 64'h0, 64'h0, 64'h1};
  localparam logic [319:0] SINGLE_RES = {64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1};

  localparam logic [4:0] TBL [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  localparam int COLS [4] = '{4, 1, 8, 64};
  localparam int WINDOW = 75;

  logic              clock_i = 1'b0;
  logic              resetb_i;
  logic              start_i;
  logic [319:0]      state_i;
  logic [3:0][319:0] stateOut;
  logic [3:0]        busyOut;
  logic [3:0]        doneOut;

  int compared = 0;
  int mismatched = 0;

  int           firstDone [4];
  int           secondDone [4];
  int           doneCnt [4];
  int           busyCnt [4];
  logic [319:0] res1 [4];
  logic [319:0] res2 [4];
  logic [319:0] stAtRst;
  logic         busyAtRst;

  always #5 clock_i = ~clock_i;

  subst_layer_iter #(.COLS_PER_CYCLE(4)) dutC4 (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .state_i(state_i),
    .state_o(stateOut[0]), .busy_o(busyOut[0]), .done_o(doneOut[0]));
  subst_layer_iter #(.COLS_PER_CYCLE(1)) dutC1 (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .state_i(state_i),
    .state_o(stateOut[1]), .busy_o(busyOut[1]), .done_o(doneOut[1]));
  subst_layer_iter #(.COLS_PER_CYCLE(8)) dutC8 (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .state_i(state_i),
    .state_o(stateOut[2]), .busy_o(busyOut[2]), .done_o(doneOut[2]));
  subst_layer_iter #(.COLS_PER_CYCLE(64)) dutC64 (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .state_i(state_i),
    .state_o(stateOut[3]), .busy_o(busyOut[3]), .done_o(doneOut[3]));

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Column 0 holds a, column 63 holds b, every other column holds rest.
  function automatic logic [319:0] colState(input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] rest);
    logic [63:0] x [5];
    for (int i = 0; i < 5; i++) begin
      x[i]     = {64{rest[4-i]}};
      x[i][0]  = a[4-i];
      x[i][63] = b[4-i];
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic doReset();
    resetb_i = 1'b0;
    start_i  = 1'b0;
    tick();
    tick();
    resetb_i = 1'b1;
  endtask

  // Starts a run with s1 at edge 0 and watches every instance for WINDOW edges.
  // midCycle: pulse start with s2 after that sample; hold: keep start high with s2;
  // rstCycle: pull reset low for the edge following that sample.
  task automatic applyStimulus(input logic [319:0] s1, input logic [319:0] s2,
                               input int midCycle, input bit hold, input int rstCycle);
    for (int d = 0; d < 4; d++) begin
      firstDone[d]  = -1;
      secondDone[d] = -1;
      doneCnt[d]    = 0;
      busyCnt[d]    = 0;
      res1[d]       = 'x;
      res2[d]       = 'x;
    end
    stAtRst   = 'x;
    busyAtRst = 1'bx;
    resetb_i  = 1'b1;
    start_i   = 1'b1;
    state_i   = s1;
    for (int cyc = 0; cyc <= WINDOW; cyc++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        if (busyOut[d]) busyCnt[d]++;
        if (doneOut[d]) begin
          doneCnt[d]++;
          if (firstDone[d] < 0) begin
            firstDone[d] = cyc;
            res1[d]      = stateOut[d];
          end else if (secondDone[d] < 0) begin
            secondDone[d] = cyc;
            res2[d]       = stateOut[d];
          end
        end
      end
      if (rstCycle >= 0 && cyc == rstCycle + 1) begin
        stAtRst   = stateOut[0];
        busyAtRst = busyOut[0];
      end
      if (hold || cyc == midCycle) begin
        start_i = 1'b1;
        state_i = s2;
      end else begin
        start_i = 1'b0;
        state_i = ~s1;
      end
      resetb_i = (cyc == rstCycle) ? 1'b0 : 1'b1;
    end
    start_i  = 1'b0;
    resetb_i = 1'b1;
  endtask

  task automatic checkRun(input string tag, input logic [319:0] exp);
    for (int d = 0; d < 4; d++) begin
      checkOutput($sformatf("%s.result.c%0d", tag, COLS[d]), res1[d], exp);
      checkOutput($sformatf("%s.doneEdge.c%0d", tag, COLS[d]), 320'(firstDone[d]), 320'(64 / COLS[d]));
      checkOutput($sformatf("%s.busyCycles.c%0d", tag, COLS[d]), 320'(busyCnt[d]), 320'(64 / COLS[d]));
      checkOutput($sformatf("%s.doneCount.c%0d", tag, COLS[d]), 320'(doneCnt[d]), 320'(1));
    end
  endtask

  initial begin
    resetb_i = 1'b0;
    start_i  = 1'b1;
    state_i  = '1;
    tick();
    tick();
    for (int d = 0; d < 4; d++)
      checkOutput($sformatf("reset.state.c%0d", COLS[d]), stateOut[d], 320'(0));
    checkOutput("reset.busy", 320'(busyOut), 320'(0));
    checkOutput("reset.done", 320'(doneOut), 320'(0));
    resetb_i = 1'b1;
    start_i  = 1'b0;
    tick();

    applyStimulus(ZERO_IN, ZERO_IN, -1, 1'b0, -1);
    checkRun("zero", ZERO_RES);
    applyStimulus(ONES_IN, ZERO_IN, -1, 1'b0, -1);
    checkRun("ones", ONES_RES);
    applyStimulus(SINGLE_IN, ZERO_IN, -1, 1'b0, -1);
    checkRun("single", SINGLE_RES);

    for (int v = 0; v < 32; v++) begin
      applyStimulus(colState(5'(v), 5'(31 - v), 5'h00), ZERO_IN, -1, 1'b0, -1);
      checkOutput($sformatf("table.v%0d", v), res1[0],
                  colState(TBL[v], TBL[31 - v], 5'h04));
    end

    applyStimulus(ONES_IN, ZERO_IN, 5, 1'b0, -1);
    checkOutput("midStart.result", res1[0], ONES_RES);
    checkOutput("midStart.doneEdge", 320'(firstDone[0]), 320'(16));
    checkOutput("midStart.doneCount", 320'(doneCnt[0]), 320'(1));

    applyStimulus(ZERO_IN, SINGLE_IN, -1, 1'b1, -1);
    checkOutput("held.first", res1[0], ZERO_RES);
    checkOutput("held.firstEdge", 320'(firstDone[0]), 320'(16));
    checkOutput("held.second", res2[0], SINGLE_RES);
    checkOutput("held.secondEdge", 320'(secondDone[0]), 320'(33));
    doReset();
    tick();

    applyStimulus(ONES_IN, ZERO_IN, -1, 1'b0, 6);
    checkOutput("abort.state", stAtRst, 320'(0));
    checkOutput("abort.busy", 320'(busyAtRst), 320'(0));
    checkOutput("abort.doneCount", 320'(doneCnt[0]), 320'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/subst_layer_iter.md
# subst_layer_iter

Iterative ASCON substitution layer (p_S). Applies the 5-bit `s_box` to all 64 columns of the 320-bit permutation state, COLS_PER_CYCLE columns per clock, and trades latency for area. It sits between the constant-addition stage (upstream, supplies `state_i`) and the linear diffusion layer (downstream, consumes `state_o` on `done_o`). A start/done handshake lets the permutation controller sequence it.

## Interface
- COLS_PER_CYCLE, default 4: number of `s_box` instances and columns substituted per cycle. Legal values are 1, 2, 4, 8, 16, 32, 64 (must divide 64).
- clock_i  in  1  system clock; all state changes on the rising edge.
- resetb_i  in  1  reset, synchronous, active-low.
- start_i  in  1  request to substitute `state_i`; sampled only in IDLE or DONE.
- state_i  in  320 (type_state, x0..x4 × 64)  state to substitute; captured on an accepted start.
- state_o  out  320 (type_state)  internal state register, always driven. Holds the final result while in DONE and in IDLE after a completed run.
- busy_o  out  1  high while in RUN.
- done_o  out  1  high for exactly one cycle (DONE state) when `state_o` holds the complete result.

## Operation
- Column j (0..63) is the s_box input {x0[j], x1[j], x2[j], x3[j], x4[j]}, with x0 as the MSB. The s_box output is written back to the same bit positions in the same order.
- Internal registers:
  - state_reg (320 bits), which drives `state_o`.
  - group counter cnt, width log2(64/COLS_PER_CYCLE), minimum 1 bit.
  - FSM with 3 states.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - With start_i=1: state_reg <= state_i, cnt <= 0, go to RUN.
  - Otherwise hold.
- RUN:
  - Each cycle, substitute columns cnt·C .. cnt·C+C-1 of state_reg in place. The C `s_box` instances are combinational. Other columns are unchanged.
  - If cnt = 64/C − 1, go to DONE. Otherwise cnt <= cnt+1.
  - start_i is ignored in RUN.
- DONE:
  - done_o=1.
  - With start_i=1: behave as an accepted start in IDLE (load state_i, cnt <= 0, go to RUN). This allows back-to-back operation.
  - Otherwise go to IDLE and hold state_reg.
- Counter never wraps in RUN. The terminal compare ends the run exactly at group 64/C − 1.
- For COLS_PER_CYCLE=64: a single RUN cycle, then DONE.
- Reset (resetb_i=0 at an edge), valid in any state including mid-RUN:
  - FSM <= IDLE, cnt <= 0, state_reg <= 0.
  - Any partial result is discarded; no done_o is produced for the aborted run.

## Timing
- Reset values: state_o = 320'h0, busy_o = 0, done_o = 0.
- busy_o and done_o are decoded from FSM registers only (Moore), with no combinational path from inputs.
- Start accepted at edge E0:
  - busy_o = 1 from after E0 until after edge E(N), where N = 64/C.
  - done_o = 1 in the cycle after E(N).
  - Latency from accepting edge to done_o is N+1 cycles (17 for C=4).
- Between E0 and E(N), state_o shows partially substituted state. Downstream may sample it only when done_o=1, or in IDLE after a completed run.
- Back-to-back: with start_i held high, a new start is accepted on the DONE edge. Throughput is one result per N+1 cycles.
- state_i need only be valid at the accepting edge.

## Test plan
- **Reset:** hold resetb_i=0 for 2 cycles with start_i=1 → state_o=0, busy_o=0, done_o=0. Release, then assert start_i 1 cycle with state_i all-zero → busy_o high 16 cycles (C=4), done_o 1 cycle. Result: x2=64'hFFFF_FFFF_FFFF_FFFF, x0=x1=x3=x4=0 (s_box(0x00)=0x04).
- **All ones:** state_i all-ones → x0=x2=x3=x4=64'hFFFF_FFFF_FFFF_FFFF, x1=0 (s_box(0x1F)=0x17).
- **Single column, bit-order check:** x4=64'h1, others 0 → x0=0, x1=64'h1, x2=64'hFFFF_FFFF_FFFF_FFFF, x3=64'h1, x4=64'h1 (s_box(0x01)=0x0B).
- **Exhaustive table:** 32 runs; each loads column 0 with value v (0..31) and column 63 with 31−v. Check both columns against the ASCON table 04,0B,1F,14,1A,15,09,02,1B,05,08,12,1D,03,06,1C,1E,13,07,0E,00,0D,11,18,10,0C,01,19,16,0A,0F,17.
- **Control corners:**
  - start_i pulsed mid-RUN with different state_i → ignored; result matches the first operand.
  - start_i held high → second run begins on the DONE edge.
  - resetb_i=0 at RUN cycle 7 → next cycle state_o=0, busy_o=0, no done_o.
- **Parameter sweep:** repeat the all-zero and single-column tests for C=1, 8, 64 → latency 64+1, 8+1, 1+1 cycles; identical results.
